// File: rtl/bus_fabric.sv
// bus_fabric: single-master bus fabric that decodes a region and forwards one transaction at a time to a slave channel
module bus_fabric #(
   parameter int size_addr = 8,
   parameter int size_data = 8,
   parameter int sel_bits = 1,
   parameter logic [2**sel_bits-1:0] map_mask = '1,
   parameter int timeout = 15
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                read,
   input  logic                                write,
   input  logic [size_addr-1:0]                address,
   input  logic [size_data-1:0]                data_out,
   output logic [size_data-1:0]                data_in,
   output logic                                ready,
   output logic                                error,
   output logic [2**sel_bits-1:0]              s_read,
   output logic [2**sel_bits-1:0]              s_write,
   output logic [size_addr-sel_bits-1:0]       s_address,
   output logic [size_data-1:0]                s_data_out,
   input  logic [(2**sel_bits)*size_data-1:0]  s_data_in,
   input  logic [2**sel_bits-1:0]              s_ready
);
   localparam int n_sel = 2**sel_bits;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t r_state;
   logic [sel_bits-1:0] r_sel;
   logic r_op_rd;
   logic [7:0] r_cnt;
   logic [sel_bits-1:0] w_sel;
   logic [n_sel-1:0] w_onehot;
   logic [7:0] w_cnt_next;
   logic w_hit;
   logic [size_data-1:0] w_slice;
   assign w_sel = address[size_addr-1 -: sel_bits];
   assign w_onehot = n_sel'(1) << w_sel;
   assign w_cnt_next = r_cnt + 8'd1;
   assign w_hit = s_ready[r_sel];
   assign w_slice = s_data_in[r_sel*size_data +: size_data];
   // request decode, slave access with timeout, and one-cycle response pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_sel <= '0;
         r_op_rd <= 1'b0;
         r_cnt <= '0;
         data_in <= '0;
         ready <= 1'b0;
         error <= 1'b0;
         s_read <= '0;
         s_write <= '0;
         s_address <= '0;
         s_data_out <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (read && write) begin
                  r_state <= RESP;
                  ready <= 1'b1;
                  error <= 1'b1;
               end else if (read ^ write) begin
                  r_op_rd <= read;
                  r_sel <= w_sel;
                  s_address <= address[size_addr-sel_bits-1:0];
                  s_data_out <= data_out;
                  if (map_mask[w_sel]) begin
                     r_state <= ACCESS;
                     r_cnt <= '0;
                     s_read <= read ? w_onehot : '0;
                     s_write <= write ? w_onehot : '0;
                  end else begin
                     r_state <= RESP;
                     ready <= 1'b1;
                     error <= 1'b1;
                     if (read) data_in <= '1;
                  end
               end
            end
            ACCESS: begin
               r_cnt <= w_cnt_next;
               if (w_hit || w_cnt_next == 8'(timeout)) begin
                  r_state <= RESP;
                  ready <= 1'b1;
                  error <= !w_hit;
                  s_read <= '0;
                  s_write <= '0;
                  if (r_op_rd) data_in <= w_hit ? w_slice : '1;
               end
            end
            RESP: begin
               r_state <= IDLE;
               ready <= 1'b0;
               error <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: scoreboard bench covering decode, wait states, unmapped regions, timeouts, reset abort and wide configs
module tb_bus_fabric;
   typedef struct packed {logic err; logic [15:0] data;} exp_t;
   exp_t q[$];
   exp_t e;
   int vecs = 0;
   int errs = 0;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic read = 1'b0;
   logic write = 1'b0;
   logic [7:0] address = '0;
   logic [7:0] data_out = '0;
   logic [7:0] a_din, b_din;
   logic [15:0] c_din;
   logic a_rdy, a_err, b_rdy, b_err, c_rdy, c_err;
   logic [1:0] a_sr, a_sw, b_sr, b_sw;
   logic [3:0] c_sr, c_sw;
   logic [6:0] a_sad, b_sad;
   logic [5:0] c_sad;
   logic [7:0] a_sdo, b_sdo;
   logic [15:0] c_sdo;
   logic [15:0] a_sdi = '0;
   logic [15:0] b_sdi = '0;
   logic [63:0] c_sdi = '0;
   logic [1:0] a_srdy = '0;
   logic [1:0] b_srdy = '0;
   logic [3:0] c_srdy = '0;
   logic [3:0] oh;

   always #5 clk = ~clk;

   bus_fabric u_a (
      .clk(clk), .reset(reset), .read(read), .write(write), .address(address), .data_out(data_out),
      .data_in(a_din), .ready(a_rdy), .error(a_err), .s_read(a_sr), .s_write(a_sw), .s_address(a_sad),
      .s_data_out(a_sdo), .s_data_in(a_sdi), .s_ready(a_srdy));

   bus_fabric #(.map_mask(2'b01), .timeout(4)) u_b (
      .clk(clk), .reset(reset), .read(read), .write(write), .address(address), .data_out(data_out),
      .data_in(b_din), .ready(b_rdy), .error(b_err), .s_read(b_sr), .s_write(b_sw), .s_address(b_sad),
      .s_data_out(b_sdo), .s_data_in(b_sdi), .s_ready(b_srdy));

   bus_fabric #(.sel_bits(2), .size_data(16)) u_c (
      .clk(clk), .reset(reset), .read(read), .write(write), .address(address), .data_out({8'h00, data_out}),
      .data_in(c_din), .ready(c_rdy), .error(c_err), .s_read(c_sr), .s_write(c_sw), .s_address(c_sad),
      .s_data_out(c_sdo), .s_data_in(c_sdi), .s_ready(c_srdy));

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; read = 1'b0; write = 1'b0;
      a_srdy = '0; b_srdy = '0; c_srdy = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++;
      if ({a_sr, a_sw, a_rdy, a_err, a_din, a_sad, a_sdo} !== '0) begin
         errs++; $display("FAIL reset_a got %h exp 0", {a_sr, a_sw, a_rdy, a_err, a_din, a_sad, a_sdo});
      end
      vecs++;
      if ({c_sr, c_sw, c_rdy, c_err, c_din, c_sad, c_sdo} !== '0) begin
         errs++; $display("FAIL reset_c got %h exp 0", {c_sr, c_sw, c_rdy, c_err, c_din, c_sad, c_sdo});
      end
   endtask

   task automatic test_read();
      do_reset();
      read = 1'b1; address = 8'h85;
      q.push_back('{err: 1'b0, data: 16'h003C});
      @(negedge clk);
      vecs++;
      if ({a_sr, a_sw, a_sad, a_rdy} !== {2'b10, 2'b00, 7'h05, 1'b0}) begin
         errs++; $display("FAIL rd_strobe got %h exp %h", {a_sr, a_sw, a_sad, a_rdy}, {2'b10, 2'b00, 7'h05, 1'b0});
      end
      read = 1'b0; a_sdi = 16'h3C00; a_srdy = 2'b10;
      @(negedge clk);
      a_srdy = '0;
      vecs++;
      if (a_rdy !== 1'b1 || q.size() == 0) begin
         errs++; $display("FAIL rd_ready got %b exp 1", a_rdy);
      end else begin
         e = q.pop_front();
         vecs++;
         if ({a_err, a_din, a_sr} !== {e.err, e.data[7:0], 2'b00}) begin
            errs++; $display("FAIL rd_resp got %h exp %h", {a_err, a_din, a_sr}, {e.err, e.data[7:0], 2'b00});
         end
      end
      @(negedge clk);
      vecs++;
      if ({a_rdy, a_err} !== 2'b00) begin
         errs++; $display("FAIL rd_pulse got %b exp 00", {a_rdy, a_err});
      end
   endtask

   task automatic test_write_wait();
      write = 1'b1; address = 8'h10; data_out = 8'h5A;
      q.push_back('{err: 1'b0, data: 16'h003C});
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         vecs++;
         if ({a_sw, a_sr, a_sdo, a_sad, a_rdy} !== {2'b01, 2'b00, 8'h5A, 7'h10, 1'b0}) begin
            errs++; $display("FAIL wr_hold%0d got %h exp %h", c, {a_sw, a_sr, a_sdo, a_sad, a_rdy}, {2'b01, 2'b00, 8'h5A, 7'h10, 1'b0});
         end
         write = 1'b0;
         if (c == 2) begin address = 8'hFF; data_out = 8'hEE; write = 1'b1; end
         if (c == 3) write = 1'b0;
         if (c == 4) a_srdy = 2'b01;
      end
      @(negedge clk);
      a_srdy = '0;
      vecs++;
      if (a_rdy !== 1'b1 || q.size() == 0) begin
         errs++; $display("FAIL wr_ready got %b exp 1", a_rdy);
      end else begin
         e = q.pop_front();
         vecs++;
         if ({a_err, a_din, a_sw} !== {e.err, e.data[7:0], 2'b00}) begin
            errs++; $display("FAIL wr_resp got %h exp %h", {a_err, a_din, a_sw}, {e.err, e.data[7:0], 2'b00});
         end
      end
      @(negedge clk);
   endtask

   task automatic test_unmapped();
      do_reset();
      read = 1'b1; address = 8'h80;
      @(negedge clk);
      read = 1'b0;
      vecs++;
      if ({b_rdy, b_err, b_sr, b_sw} !== {1'b1, 1'b1, 2'b00, 2'b00}) begin
         errs++; $display("FAIL unmapped got %b exp 110000", {b_rdy, b_err, b_sr, b_sw});
      end
      @(negedge clk);
      vecs++;
      if ({b_rdy, b_err} !== 2'b00) begin
         errs++; $display("FAIL unmapped_pulse got %b exp 00", {b_rdy, b_err});
      end
   endtask

   task automatic test_timeout();
      for (int t = 0; t < 2; t++) begin
         do_reset();
         b_sdi = 16'h0077;
         read = 1'b1; address = 8'h00;
         q.push_back(t == 0 ? '{err: 1'b1, data: 16'h00FF} : '{err: 1'b0, data: 16'h0077});
         for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            read = 1'b0;
            vecs++;
            if ({b_sr, b_rdy} !== {2'b01, 1'b0}) begin
               errs++; $display("FAIL to%0d_strobe%0d got %b exp 010", t, c, {b_sr, b_rdy});
            end
            if (c == 4 && t == 1) b_srdy = 2'b01;
         end
         @(negedge clk);
         b_srdy = '0;
         vecs++;
         if (b_rdy !== 1'b1 || q.size() == 0) begin
            errs++; $display("FAIL to%0d_ready got %b exp 1", t, b_rdy);
         end else begin
            e = q.pop_front();
            vecs++;
            if ({b_err, b_din, b_sr} !== {e.err, e.data[7:0], 2'b00}) begin
               errs++; $display("FAIL to%0d_resp got %h exp %h", t, {b_err, b_din, b_sr}, {e.err, e.data[7:0], 2'b00});
            end
         end
      end
   endtask

   task automatic test_both_and_abort();
      do_reset();
      read = 1'b1; write = 1'b1; address = 8'h85;
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      vecs++;
      if ({a_rdy, a_err, a_sr, a_sw} !== {1'b1, 1'b1, 2'b00, 2'b00}) begin
         errs++; $display("FAIL both got %b exp 110000", {a_rdy, a_err, a_sr, a_sw});
      end
      @(negedge clk);
      read = 1'b1; address = 8'h85; a_sdi = 16'h9100;
      @(negedge clk);
      read = 1'b0; a_srdy = 2'b10;
      @(negedge clk);
      a_srdy = '0;
      vecs++;
      if ({a_rdy, a_din} !== {1'b1, 8'h91}) begin
         errs++; $display("FAIL abort_pre got %h exp 191", {a_rdy, a_din});
      end
      @(negedge clk);
      read = 1'b1; address = 8'h85;
      @(negedge clk);
      read = 1'b0;
      vecs++;
      if (a_sr !== 2'b10) begin
         errs++; $display("FAIL abort_access got %b exp 10", a_sr);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vecs++;
      if ({a_sr, a_sw, a_rdy, a_err, a_din} !== '0) begin
         errs++; $display("FAIL abort_reset got %h exp 0", {a_sr, a_sw, a_rdy, a_err, a_din});
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vecs++;
         if ({a_rdy, a_sr} !== 3'b000) begin
            errs++; $display("FAIL abort_quiet%0d got %b exp 000", c, {a_rdy, a_sr});
         end
      end
   endtask

   task automatic test_back_to_back_regions();
      do_reset();
      for (int k = 0; k < 4; k++) c_sdi[k*16 +: 16] = 16'($urandom);
      address = {2'd0, 6'($urandom)};
      read = 1'b1;
      q.push_back('{err: 1'b0, data: c_sdi[15:0]});
      for (int i = 0; i < 4; i++) begin
         oh = 4'b0001 << i;
         @(negedge clk);
         vecs++;
         if ({c_sr, c_sw, c_sad} !== {oh, 4'b0000, address[5:0]}) begin
            errs++; $display("FAIL reg%0d_strobe got %h exp %h", i, {c_sr, c_sw, c_sad}, {oh, 4'b0000, address[5:0]});
         end
         c_srdy = ~oh;
         @(negedge clk);
         vecs++;
         if ({c_rdy, c_sr} !== {1'b0, oh}) begin
            errs++; $display("FAIL reg%0d_ignore got %b exp %b", i, {c_rdy, c_sr}, {1'b0, oh});
         end
         c_srdy = oh;
         @(negedge clk);
         c_srdy = '0;
         vecs++;
         if (c_rdy !== 1'b1 || q.size() == 0) begin
            errs++; $display("FAIL reg%0d_ready got %b exp 1", i, c_rdy);
         end else begin
            e = q.pop_front();
            vecs++;
            if ({c_err, c_din} !== {e.err, e.data}) begin
               errs++; $display("FAIL reg%0d_data got %h exp %h", i, {c_err, c_din}, {e.err, e.data});
            end
         end
         if (i < 3) begin
            address = {2'(i + 1), 6'($urandom)};
            q.push_back('{err: 1'b0, data: c_sdi[(i+1)*16 +: 16]});
         end else read = 1'b0;
         @(negedge clk);
         vecs++;
         if (c_rdy !== 1'b0) begin
            errs++; $display("FAIL reg%0d_idle got %b exp 0", i, c_rdy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_wait();
      test_unmapped();
      test_timeout();
      test_both_and_abort();
      test_back_to_back_regions();
      vecs++;
      if (q.size() != 0) begin
         errs++; $display("FAIL scoreboard_left got %0d exp 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter size_addr, default 8: master address width in bits.
REQ-002 Parameter size_data, default 8: data width in bits.
REQ-003 Parameter sel_bits, default 1: region-select bits, taken from address[size_addr-1 -: sel_bits]; n_sel = 2**sel_bits slave channels.
REQ-004 Parameter map_mask, default all ones (n_sel bits): bit i=1 means region i is mapped.
REQ-005 Parameter timeout, default 15: maximum ACCESS cycles before an error response; legal range 1..255.
REQ-006 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port read, input, 1: master read request.
REQ-009 Port write, input, 1: master write request.
REQ-010 Port address, input, size_addr: master address.
REQ-011 Port data_out, input, size_data: master write data.
REQ-012 Port data_in, output, size_data: registered read data returned to the master.
REQ-013 Port ready, output, 1: single-cycle transaction-complete pulse.
REQ-014 Port error, output, 1: qualifies ready; 1 = transaction failed.
REQ-015 Port s_read, output, n_sel: one-hot read strobe per channel.
REQ-016 Port s_write, output, n_sel: one-hot write strobe per channel.
REQ-017 Port s_address, output, size_addr-sel_bits: latched address with the select bits stripped.
REQ-018 Port s_data_out, output, size_data: latched write data, broadcast to all channels.
REQ-019 Port s_data_in, input, n_sel*size_data: packed read data; channel i occupies bits [i*size_data +: size_data].
REQ-020 Port s_ready, input, n_sel: per-channel completion.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-022 In IDLE with read XOR write high, the block SHALL latch address, data_out, operation and region index, then go to ACCESS if the region is mapped, else go to RESP with error=1.
REQ-023 In IDLE with read and write both high, the block SHALL strobe no slave and go to RESP with error=1.
REQ-024 In ACCESS, exactly the selected channel's s_read or s_write bit SHALL be high every cycle; all other strobe bits SHALL stay 0.
REQ-025 In ACCESS, when s_ready of the selected channel is high, the block SHALL capture that channel's s_data_in slice into data_in (reads only) and go to RESP with error=0.
REQ-026 s_ready on unselected channels SHALL be ignored.
REQ-027 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
REQ-028 If the counter reaches timeout without the selected s_ready, the block SHALL go to RESP with error=1; on a read, data_in SHALL become all ones.
REQ-029 If s_ready arrives in the same cycle the counter reaches timeout, the block SHALL treat it as success.
REQ-030 In RESP, ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-031 Minimum latency is request sampled in cycle 0, strobe in cycle 1, s_ready in cycle 1, ready in cycle 2.
REQ-032 Outside IDLE, changes on read, write, address and data_out SHALL be ignored.
REQ-033 A request still held in IDLE after RESP SHALL start a new transaction; the master must drop the request in the cycle after ready.
REQ-034 error SHALL be 0 whenever ready is 0.
REQ-035 data_in SHALL hold its value except on a read completion (success or error) and on reset.

Reset
REQ-036 With reset high at a clock edge, the block SHALL enter IDLE and clear the counter; s_read, s_write, ready and error SHALL be 0; data_in, s_address and s_data_out SHALL be 0.
REQ-037 Reset SHALL take priority in every state, and an in-flight transaction SHALL be abandoned with no ready pulse.

Verification
REQ-038 Defaults; read address 0x85; channel 1 returns 0x3C with s_ready in its first cycle -> s_read=2'b10 and s_address=0x05 in cycle 1; ready=1, error=0, data_in=0x3C in cycle 2.
REQ-039 Write 0x5A to 0x10; s_ready[0] delayed 3 cycles -> s_write=2'b01 and s_data_out=0x5A held for 4 cycles; ready one cycle later; error=0; data_in unchanged.
REQ-040 map_mask=2'b01; read 0x80 -> no strobe, ready=1 and error=1 in cycle 1.
REQ-041 timeout=4; read 0x00, s_ready never asserted -> strobe for 4 cycles, then ready=1, error=1, data_in=0xFF; s_ready in cycle 4 instead -> error=0.
REQ-042 read and write both high -> error pulse, no strobes; reset asserted in ACCESS -> strobes 0 next cycle, no ready pulse, data_in=0x00.
REQ-043 sel_bits=2, size_data=16; consecutive reads to each of 4 regions -> correct one-hot strobe and correct 16-bit slice returned in each transaction.
